// File: rtl/codec_write_arbiter.sv
// Round-robin arbiter feeding stereo samples from two sources into a codec DAC FIFO.
// Issues a zero filler sample when no source has delivered for UNDERRUN_LIMIT idle cycles.
module codec_write_arbiter #(
    parameter int unsigned W              = 24,
    parameter int unsigned UNDERRUN_LIMIT = 1041
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         src0_valid,
    input  logic [W-1:0] src0_left,
    input  logic [W-1:0] src0_right,
    output logic         src0_ready,
    input  logic         src1_valid,
    input  logic [W-1:0] src1_left,
    input  logic [W-1:0] src1_right,
    output logic         src1_ready,
    input  logic         mute,
    input  logic         write_ready,
    output logic         write,
    output logic [W-1:0] writedata_left,
    output logic [W-1:0] writedata_right,
    output logic         grant,
    output logic [15:0]  underrun_count
);

    localparam int unsigned LimW = $clog2(UNDERRUN_LIMIT + 1);
    localparam int unsigned CntW = (LimW > 11) ? LimW : 11;

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e          state_q, state_d;
    logic            write_q, write_d;
    logic [W-1:0]    wdata_left_q, wdata_left_d;
    logic [W-1:0]    wdata_right_q, wdata_right_d;
    logic            grant_q, grant_d;
    logic [15:0]     underrun_count_q, underrun_count_d;
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

    logic src0_win, src1_win, accept;

    // On contention the source that did not win last time gets the slot.
    always_comb begin
        src0_win   = src0_valid && (!src1_valid || grant_q);
        src1_win   = src1_valid && (!src0_valid || !grant_q);
        accept     = (state_q == StIdle) && !reset;
        src0_ready = accept && src0_win;
        src1_ready = accept && src1_win;
    end

    always_comb begin
        state_d          = state_q;
        write_d          = 1'b0;
        wdata_left_d     = wdata_left_q;
        wdata_right_d    = wdata_right_q;
        grant_d          = grant_q;
        underrun_count_d = underrun_count_q;
        idle_cnt_d       = idle_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (src0_win || src1_win) begin
                    wdata_left_d  = mute ? '0 : (src1_win ? src1_left : src0_left);
                    wdata_right_d = mute ? '0 : (src1_win ? src1_right : src0_right);
                    grant_d       = src1_win;
                    idle_cnt_d    = '0;
                    state_d       = StHold;
                end else if (idle_cnt_q >= CntW'(UNDERRUN_LIMIT)) begin
                    // A late source still wins over the filler in the limit cycle.
                    wdata_left_d  = '0;
                    wdata_right_d = '0;
                    if (underrun_count_q != 16'hFFFF) begin
                        underrun_count_d = underrun_count_q + 16'd1;
                    end
                    idle_cnt_d = '0;
                    state_d    = StHold;
                end else begin
                    idle_cnt_d = idle_cnt_q + CntW'(1);
                end
            end
            StHold: begin
                if (write_ready) begin
                    write_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q          <= StIdle;
            write_q          <= 1'b0;
            wdata_left_q     <= '0;
            wdata_right_q    <= '0;
            grant_q          <= 1'b1;
            underrun_count_q <= '0;
            idle_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            wdata_left_q     <= wdata_left_d;
            wdata_right_q    <= wdata_right_d;
            grant_q          <= grant_d;
            underrun_count_q <= underrun_count_d;
            idle_cnt_q       <= idle_cnt_d;
        end
    end

    assign write           = write_q;
    assign writedata_left  = wdata_left_q;
    assign writedata_right = wdata_right_q;
    assign grant           = grant_q;
    assign underrun_count  = underrun_count_q;

endmodule

// File: tb/tb_codec_write_arbiter.sv
// Self-checking bench for codec_write_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model built from the arbitration and underrun rules.
module tb_codec_write_arbiter;

    localparam int W   = 24;
    localparam int LIM = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         src0_valid, src1_valid, src0_ready, src1_ready;
    logic [W-1:0] src0_left, src0_right, src1_left, src1_right;
    logic         mute, write_ready, write, grant;
    logic [W-1:0] writedata_left, writedata_right;
    logic [15:0]  underrun_count;

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    codec_write_arbiter #(
        .W              (W),
        .UNDERRUN_LIMIT (LIM)
    ) dut (
        .CLOCK_50        (clk),
        .reset           (reset),
        .src0_valid      (src0_valid),
        .src0_left       (src0_left),
        .src0_right      (src0_right),
        .src0_ready      (src0_ready),
        .src1_valid      (src1_valid),
        .src1_left       (src1_left),
        .src1_right      (src1_right),
        .src1_ready      (src1_ready),
        .mute            (mute),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .grant           (grant),
        .underrun_count  (underrun_count)
    );

    // Leaves the bench at a falling edge with reset released and the idle counter at zero.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; src0_valid = 1'b0; src1_valid = 1'b0; mute = 1'b0; write_ready = 1'b0;
        src0_left = '0; src0_right = '0; src1_left = '0; src1_right = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; src0_valid = 1'b1; src1_valid = 1'b1; write_ready = 1'b1;
        src0_left = 24'hABCDEF; src1_left = 24'h13579B;
        repeat (2) begin
            #1;
            tests_run++;
            if ({src0_ready, src1_ready} !== 2'b00) begin
                failures++;
                $display("FAIL reset_ready: got %b want 00", {src0_ready, src1_ready});
            end
            @(negedge clk);
        end
        src0_valid = 1'b0; src1_valid = 1'b0; write_ready = 1'b0; reset = 1'b0;
        #1;
        tests_run++;
        if ({write, grant, underrun_count} !== {1'b0, 1'b1, 16'd0}) begin
            failures++;
            $display("FAIL reset_ctrl: write/grant/uc got %b/%b/%0d want 0/1/0",
                     write, grant, underrun_count);
        end
        tests_run++;
        if ({writedata_left, writedata_right} !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h/%h want 0/0", writedata_left, writedata_right);
        end
        tests_run++;
        if ({src0_ready, src1_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle_ready: got %b want 00", {src0_ready, src1_ready});
        end
    endtask

    task automatic test_single();
        do_reset();
        src0_valid = 1'b1; src0_left = 24'h123456; src0_right = 24'h654321;
        src1_left = 24'hFFFFFF; src1_right = 24'hEEEEEE; write_ready = 1'b1;
        #1;
        tests_run++;
        if ({src0_ready, src1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL single_ready: got %b want 10", {src0_ready, src1_ready});
        end
        @(negedge clk);
        src0_valid = 1'b0;
        #1;
        tests_run++;
        if ({write, grant, src0_ready} !== 3'b000) begin
            failures++;
            $display("FAIL single_hold: write/grant/ready got %b want 000",
                     {write, grant, src0_ready});
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({write, writedata_left, writedata_right} !== {1'b1, 24'h123456, 24'h654321}) begin
            failures++;
            $display("FAIL single_write: got %b %h/%h want 1 123456/654321",
                     write, writedata_left, writedata_right);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (write !== 1'b0) begin
            failures++;
            $display("FAIL single_write_pulse: got %b want 0", write);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] a, b, exp_l;
        bit           exp_w;
        do_reset();
        a = 24'h0A0A0A; b = 24'h0B0B0B;
        src0_left = a; src0_right = ~a; src1_left = b; src1_right = ~b;
        src0_valid = 1'b1; src1_valid = 1'b1; write_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            tests_run++;
            if ({src0_ready, src1_ready} !== {k % 4 == 0, k % 4 == 2}) begin
                failures++;
                $display("FAIL rr_ready k=%0d: got %b want %b", k, {src0_ready, src1_ready},
                         {k % 4 == 0, k % 4 == 2});
            end
            exp_w = (k >= 2) && (k % 2 == 0);
            exp_l = (k % 4 == 2) ? a : b;
            tests_run++;
            if (write !== exp_w) begin
                failures++;
                $display("FAIL rr_write k=%0d: got %b want %b", k, write, exp_w);
            end
            if (exp_w) begin
                tests_run++;
                if ({writedata_left, writedata_right, grant} !== {exp_l, ~exp_l, k % 4 != 2})
                begin
                    failures++;
                    $display("FAIL rr_data k=%0d: got %h/%h g%b want %h/%h g%b", k,
                             writedata_left, writedata_right, grant, exp_l, ~exp_l, k % 4 != 2);
                end
            end
            @(negedge clk);
        end
        src0_valid = 1'b0; src1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        src1_valid = 1'b1; src1_left = 24'hC0FFEE; src1_right = 24'hBEEF01; write_ready = 1'b0;
        #1;
        tests_run++;
        if ({src0_ready, src1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_ready: got %b want 01", {src0_ready, src1_ready});
        end
        @(negedge clk);
        src0_valid = 1'b1; src0_left = 24'h111111; src1_left = 24'h222222;
        for (int i = 0; i < 10; i++) begin
            #1;
            tests_run++;
            if ({write, src0_ready, src1_ready, writedata_left, writedata_right} !==
                {3'b000, 24'hC0FFEE, 24'hBEEF01}) begin
                failures++;
                $display("FAIL bp_hold i=%0d: w/r0/r1 %b%b%b data %h/%h want 000 c0ffee/beef01",
                         i, write, src0_ready, src1_ready, writedata_left, writedata_right);
            end
            mute = ~mute;
            @(negedge clk);
        end
        src0_valid = 1'b0; src1_valid = 1'b0; mute = 1'b0; write_ready = 1'b1;
        #1;
        tests_run++;
        if (write !== 1'b0) begin
            failures++;
            $display("FAIL bp_early_write: got %b want 0", write);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({write, writedata_left, writedata_right, grant} !==
            {1'b1, 24'hC0FFEE, 24'hBEEF01, 1'b1}) begin
            failures++;
            $display("FAIL bp_release: got %b %h/%h g%b want 1 c0ffee/beef01 g1",
                     write, writedata_left, writedata_right, grant);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (write !== 1'b0) begin
            failures++;
            $display("FAIL bp_pulse: got %b want 0", write);
        end
        write_ready = 1'b0;
    endtask

    task automatic test_underrun();
        int first = -1;
        int second = -1;
        do_reset();
        src0_valid = 1'b1; src0_left = 24'h5A5A5A; src0_right = 24'hA5A5A5; write_ready = 1'b1;
        @(negedge clk);
        src0_valid = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            #1;
            if (write) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
                tests_run++;
                if ({writedata_left, writedata_right} !== '0) begin
                    failures++;
                    $display("FAIL ur_data k=%0d: got %h/%h want 0/0", k, writedata_left,
                             writedata_right);
                end
            end
            if (k == 9 || k == 19) begin
                tests_run++;
                if (underrun_count !== 16'(k / 10 + 1)) begin
                    failures++;
                    $display("FAIL ur_count k=%0d: got %0d want %0d", k, underrun_count,
                             k / 10 + 1);
                end
            end
        end
        tests_run++;
        if (first != 10 || second != 20) begin
            failures++;
            $display("FAIL ur_timing: writes at %0d,%0d want 10,20", first, second);
        end
        tests_run++;
        if ({underrun_count, grant} !== {16'd2, 1'b0}) begin
            failures++;
            $display("FAIL ur_final: uc %0d grant %b want 2 0", underrun_count, grant);
        end
    endtask

    task automatic test_underrun_priority();
        do_reset();
        write_ready = 1'b1;
        repeat (LIM) @(negedge clk);
        src1_valid = 1'b1; src1_left = 24'h765432; src1_right = 24'h234567;
        #1;
        tests_run++;
        if ({src0_ready, src1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL prio_ready: got %b want 01", {src0_ready, src1_ready});
        end
        @(negedge clk);
        src1_valid = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({write, writedata_left, writedata_right, underrun_count} !==
            {1'b1, 24'h765432, 24'h234567, 16'd0}) begin
            failures++;
            $display("FAIL prio_write: got %b %h/%h uc %0d want 1 765432/234567 uc 0",
                     write, writedata_left, writedata_right, underrun_count);
        end
    endtask

    task automatic test_mute_and_reset();
        do_reset();
        write_ready = 1'b1;
        src1_valid = 1'b1; src1_left = 24'h314159; src1_right = 24'h271828;
        @(negedge clk);
        src1_valid = 1'b0;
        @(negedge clk);
        src0_valid = 1'b1; src0_left = 24'h7FFFFF; src0_right = 24'h800000; mute = 1'b1;
        #1;
        tests_run++;
        if ({src0_ready, src1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL mute_ready: got %b want 10", {src0_ready, src1_ready});
        end
        @(negedge clk);
        src0_valid = 1'b0; mute = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({write, writedata_left, writedata_right, grant} !== {1'b1, 48'd0, 1'b0}) begin
            failures++;
            $display("FAIL mute_write: got %b %h/%h g%b want 1 0/0 g0",
                     write, writedata_left, writedata_right, grant);
        end
        @(negedge clk);
        write_ready = 1'b0;
        src1_valid = 1'b1; src1_left = 24'h0F0F0F; src1_right = 24'hF0F0F0;
        @(negedge clk);
        src1_valid = 1'b0; write_ready = 1'b1; reset = 1'b1;
        #1;
        tests_run++;
        if ({src0_ready, src1_ready, write} !== 3'b000) begin
            failures++;
            $display("FAIL hold_reset_ready: got %b want 000", {src0_ready, src1_ready, write});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if ({write, writedata_left, writedata_right} !== '0) begin
                failures++;
                $display("FAIL hold_reset_write i=%0d: got %b %h/%h want 0 0/0", i, write,
                         writedata_left, writedata_right);
            end
            @(negedge clk);
        end
        write_ready = 1'b0;
    endtask

    task automatic test_random();
        bit           m_hold, m_grant, m_write, e_r0, e_r1;
        int           m_idle, m_uc, dense;
        logic [W-1:0] m_wl, m_wr;
        do_reset();
        m_hold = 0; m_grant = 1; m_write = 0; m_idle = 0; m_uc = 0; m_wl = '0; m_wr = '0;
        dense = 1;
        for (int n = 0; n < 1500; n++) begin
            if (n % 50 == 0) dense = $urandom_range(0, 1);
            reset       = ($urandom_range(0, 299) == 0);
            src0_valid  = dense ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 14) == 0);
            src1_valid  = dense ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 14) == 0);
            src0_left   = W'($urandom()); src0_right = W'($urandom());
            src1_left   = W'($urandom()); src1_right = W'($urandom());
            mute        = ($urandom_range(0, 3) == 0);
            write_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_r0 = !reset && !m_hold && src0_valid && (!src1_valid || m_grant);
            e_r1 = !reset && !m_hold && src1_valid && (!src0_valid || !m_grant);
            tests_run++;
            if ({src0_ready, src1_ready} !== {e_r0, e_r1}) begin
                failures++;
                $display("FAIL rand_ready n=%0d: got %b want %b", n, {src0_ready, src1_ready},
                         {e_r0, e_r1});
            end
            tests_run++;
            if ({write, grant, underrun_count} !== {m_write, m_grant, 16'(m_uc)}) begin
                failures++;
                $display("FAIL rand_ctrl n=%0d: w/g/uc got %b/%b/%0d want %b/%b/%0d", n,
                         write, grant, underrun_count, m_write, m_grant, m_uc);
            end
            tests_run++;
            if ({writedata_left, writedata_right} !== {m_wl, m_wr}) begin
                failures++;
                $display("FAIL rand_data n=%0d: got %h/%h want %h/%h", n, writedata_left,
                         writedata_right, m_wl, m_wr);
            end
            if (reset) begin
                m_hold = 0; m_grant = 1; m_write = 0; m_idle = 0; m_uc = 0;
                m_wl = '0; m_wr = '0;
            end else if (m_hold) begin
                m_write = write_ready;
                if (write_ready) m_hold = 0;
            end else begin
                m_write = 0;
                if (e_r0 || e_r1) begin
                    m_wl    = mute ? '0 : (e_r1 ? src1_left : src0_left);
                    m_wr    = mute ? '0 : (e_r1 ? src1_right : src0_right);
                    m_grant = e_r1;
                    m_idle  = 0;
                    m_hold  = 1;
                end else if (m_idle >= LIM) begin
                    m_wl = '0; m_wr = '0;
                    if (m_uc < 16'hFFFF) m_uc++;
                    m_idle = 0;
                    m_hold = 1;
                end else begin
                    m_idle++;
                end
            end
            @(negedge clk);
        end
        reset = 1'b0; src0_valid = 1'b0; src1_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; src0_valid = 1'b0; src1_valid = 1'b0; mute = 1'b0; write_ready = 1'b0;
        src0_left = '0; src0_right = '0; src1_left = '0; src1_right = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_underrun();
        test_underrun_priority();
        test_mute_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
